// File: rtl/ofmap_pkg.sv
// Shared constants, lane geometry, saturation bounds and state encoding for the
// output-map packer and its requantizer.
package ofmap_pkg;
   localparam int DATA_W  = 32;
   localparam int ELEM_W  = 8;
   localparam int LANES   = DATA_W / ELEM_W;
   localparam int LANE_W  = $clog2(LANES);
   localparam int SHIFT_W = 5;

   localparam int SAT_MAX = (1 << (ELEM_W - 1)) - 1;
   localparam int SAT_MIN = -(1 << (ELEM_W - 1));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;
endpackage

// File: rtl/ofmap_requant.sv
// Combinational requantizer: rounding arithmetic right shift, optional ReLU,
// saturation to a signed element; sat flags a value clipped by saturation.
module ofmap_requant
   import ofmap_pkg::*;
#(
   parameter int ACC_WIDTH  = 32,
   parameter int ELEM_WIDTH = ELEM_W
) (
   input  logic signed [ACC_WIDTH-1:0]  in_data,
   input  logic        [SHIFT_W-1:0]    shift,
   input  logic                         relu_en,
   output logic        [ELEM_WIDTH-1:0] q,
   output logic                         sat
);
   localparam logic signed [ACC_WIDTH:0] HI = (ACC_WIDTH+1)'(SAT_MAX);
   localparam logic signed [ACC_WIDTH:0] LO = (ACC_WIDTH+1)'(SAT_MIN);

   logic signed [ACC_WIDTH:0] ext;
   logic signed [ACC_WIDTH:0] rnd;
   logic signed [ACC_WIDTH:0] r;

   // One extra bit keeps the rounding add from overflowing.
   always_comb begin
      ext = {in_data[ACC_WIDTH-1], in_data};
      rnd = '0;
      if (shift != '0) rnd[shift - SHIFT_W'(1)] = 1'b1;
      r   = (ext + rnd) >>> shift;
      if (relu_en && r[ACC_WIDTH]) r = '0;
      sat = 1'b0;
      q   = r[ELEM_WIDTH-1:0];
      if (r > HI) begin
         q   = HI[ELEM_WIDTH-1:0];
         sat = 1'b1;
      end else if (r < LO) begin
         q   = LO[ELEM_WIDTH-1:0];
         sat = 1'b1;
      end
   end
endmodule

// File: rtl/ofmap_packer.sv
// Requantizes accumulator results and packs them into stream words with strb/last.
// OFMAP_PACKER_STATS_EN adds a saturating count of clipped elements on sat_count.
//
// state | meaning
// IDLE  | waiting for start with a non-zero frame_len
// RUN   | accepting elements, emitting a word per 4 lanes or on the last element
// DRAIN | last word loaded, waiting for it to be consumed
module ofmap_packer
   import ofmap_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_W,
   parameter int ELEM_WIDTH  = ELEM_W,
   parameter int ACC_WIDTH   = 32,
   parameter int COUNT_WIDTH = 20
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         start,
   input  logic [COUNT_WIDTH-1:0]       frame_len,
   input  logic [SHIFT_W-1:0]           shift,
   input  logic                         relu_en,
   input  logic                         in_valid,
   input  logic signed [ACC_WIDTH-1:0]  in_data,
   output logic                         in_ready,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic [DATA_WIDTH/8-1:0]      o_strb,
   output logic                         o_valid,
   output logic                         o_last,
   input  logic                         o_ready,
   output logic                         busy,
   output logic                         frame_done,
   output logic [15:0]                  sat_count
);
   state_e                  state_q, state_d;
   logic [COUNT_WIDTH-1:0]  len_q, len_d, elem_cnt_q, elem_cnt_d;
   logic [SHIFT_W-1:0]      shift_q, shift_d;
   logic                    relu_q, relu_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [DATA_WIDTH-1:0]   pack_q, pack_d, o_data_q, o_data_d, word_c;
   logic [DATA_WIDTH/8-1:0] o_strb_q, o_strb_d, strb_c;
   logic                    o_valid_q, o_valid_d, o_last_q, o_last_d, done_q, done_d;
   logic                    accept, is_last;
   logic [ELEM_WIDTH-1:0]   elem_q;
   logic                    elem_sat;

   ofmap_requant #(.ACC_WIDTH(ACC_WIDTH), .ELEM_WIDTH(ELEM_WIDTH)) u_requant (
      .in_data (in_data),
      .shift   (shift_q),
      .relu_en (relu_q),
      .q       (elem_q),
      .sat     (elem_sat)
   );

`ifdef OFMAP_PACKER_STATS_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;
   assign sat_count = sat_cnt_q;
`else
   logic unused_sat;
   assign unused_sat = elem_sat;
   assign sat_count  = '0;
`endif

   assign in_ready   = (state_q == RUN) && (!o_valid_q || o_ready);
   assign accept     = in_valid && in_ready;
   assign is_last    = (elem_cnt_q == len_q - COUNT_WIDTH'(1));
   assign o_data     = o_data_q;
   assign o_strb     = o_strb_q;
   assign o_valid    = o_valid_q;
   assign o_last     = o_last_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;

   always_comb begin
      word_c = pack_q;
      word_c[int'(lane_q)*ELEM_WIDTH +: ELEM_WIDTH] = elem_q;
      for (int k = 0; k < DATA_WIDTH/8; k++) strb_c[k] = (k <= int'(lane_q));
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      shift_d    = shift_q;
      relu_d     = relu_q;
      elem_cnt_d = elem_cnt_q;
      lane_d     = lane_q;
      pack_d     = pack_q;
      o_data_d   = o_data_q;
      o_strb_d   = o_strb_q;
      o_valid_d  = o_valid_q;
      o_last_d   = o_last_q;
      done_d     = 1'b0;
`ifdef OFMAP_PACKER_STATS_EN
      sat_cnt_d  = sat_cnt_q;
`endif
      // A consumed word retires here; a load below in the same cycle overrides it.
      if (o_valid_q && o_ready) begin
         o_valid_d = 1'b0;
         o_last_d  = 1'b0;
      end
      if (clear) begin
         state_d    = IDLE;
         elem_cnt_d = '0;
         lane_d     = '0;
         pack_d     = '0;
         o_data_d   = '0;
         o_strb_d   = '0;
         o_valid_d  = 1'b0;
         o_last_d   = 1'b0;
`ifdef OFMAP_PACKER_STATS_EN
         sat_cnt_d  = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start && frame_len != '0) begin
                  state_d    = RUN;
                  len_d      = frame_len;
                  shift_d    = shift;
                  relu_d     = relu_en;
                  elem_cnt_d = '0;
                  lane_d     = '0;
                  pack_d     = '0;
`ifdef OFMAP_PACKER_STATS_EN
                  sat_cnt_d  = '0;
`endif
               end
            end
            RUN: begin
               if (accept) begin
                  elem_cnt_d = elem_cnt_q + COUNT_WIDTH'(1);
`ifdef OFMAP_PACKER_STATS_EN
                  if (elem_sat && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
`endif
                  if (lane_q == LANE_W'(LANES-1) || is_last) begin
                     o_data_d  = word_c;
                     o_strb_d  = strb_c;
                     o_valid_d = 1'b1;
                     o_last_d  = is_last;
                     lane_d    = '0;
                     pack_d    = '0;
                  end else begin
                     pack_d = word_c;
                     lane_d = lane_q + LANE_W'(1);
                  end
                  if (is_last) state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (o_valid_q && o_ready && o_last_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         elem_cnt_q <= '0;
         lane_q     <= '0;
         pack_q     <= '0;
         o_data_q   <= '0;
         o_strb_q   <= '0;
         o_valid_q  <= 1'b0;
         o_last_q   <= 1'b0;
         done_q     <= 1'b0;
`ifdef OFMAP_PACKER_STATS_EN
         sat_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         shift_q    <= shift_d;
         relu_q     <= relu_d;
         elem_cnt_q <= elem_cnt_d;
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         o_data_q   <= o_data_d;
         o_strb_q   <= o_strb_d;
         o_valid_q  <= o_valid_d;
         o_last_q   <= o_last_d;
         done_q     <= done_d;
`ifdef OFMAP_PACKER_STATS_EN
         sat_cnt_q  <= sat_cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_ofmap_packer.sv
// Self-checking bench for ofmap_packer: directed frames plus randomized frames
// compared against a behavioural requantize-and-pack reference model.
module tb_ofmap_packer;
   logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0;
   logic [19:0] frame_len = '0;
   logic [4:0]  shift = '0;
   logic        relu_en = 1'b0, in_valid = 1'b0, o_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_ready, o_valid, o_last, busy, frame_done;
   logic [31:0] o_data;
   logic [3:0]  o_strb;
   logic [15:0] sat_count;

   ofmap_packer dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .frame_len(frame_len),
      .shift(shift), .relu_en(relu_en), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .o_data(o_data), .o_strb(o_strb), .o_valid(o_valid),
      .o_last(o_last), .o_ready(o_ready), .busy(busy), .frame_done(frame_done),
      .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] d; logic [3:0] s; logic l; } word_t;

   int    checks = 0, errors = 0;
   int    cyc = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -1, hold_cnt = 0;
   bit    rdy_rand = 1'b0, bp_arm = 1'b0, saw_stall = 1'b0;
   word_t got_w[$], exp_w[$];
   int    in_vals[$];
   int    exp_sat;

   always @(posedge clk) begin
      cyc++;
      #1;
      if (hold_cnt > 0) begin
         o_ready = 1'b0;
         hold_cnt--;
      end else begin
         o_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid && o_ready) begin
            got_w.push_back('{o_data, o_strb, o_last});
            if (o_last) last_hs_cyc = cyc;
            if (bp_arm) begin
               bp_arm   = 1'b0;
               hold_cnt = 5;
            end
         end
         if (in_valid && !in_ready) saw_stall = 1'b1;
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   function automatic logic [7:0] ref_q(input int v, input int sh, input bit relu, output bit sat);
      longint r;
      r = longint'(v);
      if (sh > 0) r = r + (longint'(1) << (sh - 1));
      r = r >>> sh;
      sat = 1'b0;
      if (relu && r < 0) r = 0;
      if (r > 127) begin
         r = 127;
         sat = 1'b1;
      end else if (r < -128) begin
         r = -128;
         sat = 1'b1;
      end
      return r[7:0];
   endfunction

   function automatic void build_exp(input int sh, input bit relu);
      int n;
      n = in_vals.size();
      exp_w.delete();
      exp_sat = 0;
      for (int i = 0; i < n; i += 4) begin
         word_t w;
         w = '0;
         for (int j = 0; j < 4 && i + j < n; j++) begin
            bit s;
            w.d[8*j +: 8] = ref_q(in_vals[i+j], sh, relu, s);
            w.s[j] = 1'b1;
            exp_sat += int'(s);
         end
         w.l = (i + 4 >= n);
         exp_w.push_back(w);
      end
   endfunction

   task automatic do_start(input int len, input int sh, input bit relu);
      @(posedge clk); #1;
      start = 1'b1; frame_len = 20'(len); shift = 5'(sh); relu_en = relu;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drive_elems(input int from, input int to, input int gap_max);
      for (int i = from; i < to; i++) begin
         int guard;
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_data  = in_vals[i];
         guard    = 0;
         forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 300) begin
               checks++; errors++;
               $display("FAIL in_ready_timeout elem %0d: in_ready stayed 0 for %0d cycles", i, guard);
               break;
            end
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input int base);
      int g;
      g = 0;
      while (done_cnt == base && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (done_cnt == base) begin
         checks++; errors++;
         $display("FAIL frame_done_timeout: no frame_done within %0d cycles", g);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input int len, input int sh, input bit relu, input int gap);
      int base;
      got_w.delete();
      build_exp(sh, relu);
      base = done_cnt;
      do_start(len, sh, relu);
      drive_elems(0, len, gap);
      wait_done(base);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({o_valid, o_last, busy, frame_done, in_ready, o_data, o_strb, sat_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b l=%b busy=%b done=%b rdy=%b d=%h s=%h sat=%0d, want all 0",
                  o_valid, o_last, busy, frame_done, in_ready, o_data, o_strb, sat_count);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_full_frame();
      word_t e[2];
      int base;
      e[0] = '{32'h04030201, 4'hF, 1'b0};
      e[1] = '{32'h08070605, 4'hF, 1'b1};
      in_vals = '{1, 2, 3, 4, 5, 6, 7, 8};
      base = done_cnt;
      run_frame(8, 0, 1'b0, 0);
      checks++;
      if (got_w.size() != 2) begin
         errors++; $display("FAIL full_count: got %0d words, want 2", got_w.size());
      end else begin
         foreach (e[i]) begin
            checks++;
            if (got_w[i] !== e[i]) begin
               errors++;
               $display("FAIL full_word%0d: got %h/%h/%b want %h/%h/%b", i, got_w[i].d, got_w[i].s,
                        got_w[i].l, e[i].d, e[i].s, e[i].l);
            end
         end
      end
      checks++;
      if (done_cnt != base + 1 || done_cyc != last_hs_cyc + 1) begin
         errors++;
         $display("FAIL full_done: got %0d pulses at cyc %0d, want 1 at cyc %0d", done_cnt - base,
                  done_cyc, last_hs_cyc + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL full_idle: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_partial();
      word_t e[2];
      e[0] = '{32'h04030201, 4'hF, 1'b0};
      e[1] = '{32'h00000005, 4'h1, 1'b1};
      in_vals = '{1, 2, 3, 4, 5};
      run_frame(5, 0, 1'b0, 1);
      checks++;
      if (got_w.size() != 2) begin
         errors++; $display("FAIL partial_count: got %0d words, want 2", got_w.size());
      end else begin
         foreach (e[i]) begin
            checks++;
            if (got_w[i] !== e[i]) begin
               errors++;
               $display("FAIL partial_word%0d: got %h/%h/%b want %h/%h/%b", i, got_w[i].d, got_w[i].s,
                        got_w[i].l, e[i].d, e[i].s, e[i].l);
            end
         end
      end
   endtask

   task automatic test_requant();
      word_t e;
      int    exp_cnt;
      in_vals = '{4096, -5000};
      run_frame(2, 4, 1'b0, 0);
      e = '{32'h0000807F, 4'h3, 1'b1};
      checks++;
      if (got_w.size() != 1 || got_w[0] !== e) begin
         errors++;
         $display("FAIL requant_sat: got %0d words first %h/%h, want 1 word %h/%h", got_w.size(),
                  got_w.size() ? got_w[0].d : 0, got_w.size() ? got_w[0].s : 0, e.d, e.s);
      end
`ifdef OFMAP_PACKER_STATS_EN
      exp_cnt = 2;
`else
      exp_cnt = 0;
`endif
      checks++;
      if (int'(sat_count) != exp_cnt) begin
         errors++; $display("FAIL sat_count: got %0d want %0d", sat_count, exp_cnt);
      end
      in_vals = '{3, -3};
      run_frame(2, 1, 1'b0, 0);
      e = '{32'h0000FF02, 4'h3, 1'b1};
      checks++;
      if (got_w.size() != 1 || got_w[0] !== e) begin
         errors++;
         $display("FAIL requant_round: got %0d words first %h/%h, want 1 word %h/%h", got_w.size(),
                  got_w.size() ? got_w[0].d : 0, got_w.size() ? got_w[0].s : 0, e.d, e.s);
      end
      checks++;
      if (sat_count !== 16'd0) begin
         errors++; $display("FAIL sat_count_restart: got %0d want 0", sat_count);
      end
      in_vals = '{-20};
      run_frame(1, 0, 1'b1, 0);
      e = '{32'h00000000, 4'h1, 1'b1};
      checks++;
      if (got_w.size() != 1 || got_w[0] !== e) begin
         errors++;
         $display("FAIL requant_relu: got %0d words first %h/%h, want 1 word %h/%h", got_w.size(),
                  got_w.size() ? got_w[0].d : 0, got_w.size() ? got_w[0].s : 0, e.d, e.s);
      end
   endtask

   task automatic test_backpressure();
      word_t e[3];
      e[0] = '{32'h04030201, 4'hF, 1'b0};
      e[1] = '{32'h08070605, 4'hF, 1'b0};
      e[2] = '{32'h0C0B0A09, 4'hF, 1'b1};
      in_vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
      saw_stall = 1'b0;
      bp_arm = 1'b1;
      run_frame(12, 0, 1'b0, 0);
      checks++;
      if (!saw_stall) begin
         errors++; $display("FAIL bp_stall: in_ready never dropped under backpressure");
      end
      checks++;
      if (got_w.size() != 3) begin
         errors++; $display("FAIL bp_count: got %0d words, want 3", got_w.size());
      end else begin
         foreach (e[i]) begin
            checks++;
            if (got_w[i] !== e[i]) begin
               errors++;
               $display("FAIL bp_word%0d: got %h/%h/%b want %h/%h/%b", i, got_w[i].d, got_w[i].s,
                        got_w[i].l, e[i].d, e[i].s, e[i].l);
            end
         end
      end
   endtask

   task automatic test_clear();
      word_t e;
      int    base;
      in_vals = '{1, 2, 3, 4, 5, 6, 7, 8};
      got_w.delete();
      do_start(8, 0, 1'b0);
      drive_elems(0, 3, 0);
      base = done_cnt;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || busy !== 1'b0 || o_last !== 1'b0) begin
         errors++; $display("FAIL clear_state: got v=%b busy=%b l=%b, want 0 0 0", o_valid, busy, o_last);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (done_cnt != base || got_w.size() != 0) begin
         errors++;
         $display("FAIL clear_quiet: got %0d done pulses %0d words, want 0 0", done_cnt - base, got_w.size());
      end
      in_vals = '{9, 10, 11, 12};
      run_frame(4, 0, 1'b0, 0);
      e = '{32'h0C0B0A09, 4'hF, 1'b1};
      checks++;
      if (got_w.size() != 1 || got_w[0] !== e) begin
         errors++;
         $display("FAIL clear_restart: got %0d words first %h/%h/%b, want 1 word %h/%h/%b", got_w.size(),
                  got_w.size() ? got_w[0].d : 0, got_w.size() ? got_w[0].s : 0,
                  got_w.size() ? got_w[0].l : 0, e.d, e.s, e.l);
      end
   endtask

   task automatic test_start_ignored();
      word_t e[2];
      int base;
      e[0] = '{32'h24232221, 4'hF, 1'b0};
      e[1] = '{32'h28272625, 4'hF, 1'b1};
      in_vals = '{33, 34, 35, 36, 37, 38, 39, 40};
      got_w.delete();
      base = done_cnt;
      do_start(8, 0, 1'b0);
      drive_elems(0, 2, 0);
      start = 1'b1; frame_len = 20'd3;
      @(posedge clk); #1;
      start = 1'b0;
      drive_elems(2, 8, 0);
      wait_done(base);
      checks++;
      if (got_w.size() != 2) begin
         errors++; $display("FAIL restart_count: got %0d words, want 2", got_w.size());
      end else begin
         foreach (e[i]) begin
            checks++;
            if (got_w[i] !== e[i]) begin
               errors++;
               $display("FAIL restart_word%0d: got %h/%h/%b want %h/%h/%b", i, got_w[i].d, got_w[i].s,
                        got_w[i].l, e[i].d, e[i].s, e[i].l);
            end
         end
      end
   endtask

   task automatic test_random();
      rdy_rand = 1'b1;
      for (int f = 0; f < 8; f++) begin
         int  len, sh, base, exp_cnt;
         bit  relu;
         len  = $urandom_range(1, 30);
         sh   = $urandom_range(0, 20);
         relu = 1'($urandom_range(0, 1));
         in_vals.delete();
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1)) in_vals.push_back(int'($urandom()));
            else in_vals.push_back($urandom_range(0, 2000) - 1000);
         end
         base = done_cnt;
         run_frame(len, sh, relu, 2);
         checks++;
         if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d words, want %0d", f, got_w.size(), exp_w.size());
         end else begin
            foreach (exp_w[i]) begin
               checks++;
               if (got_w[i] !== exp_w[i]) begin
                  errors++;
                  $display("FAIL rand%0d_word%0d: got %h/%h/%b want %h/%h/%b", f, i, got_w[i].d,
                           got_w[i].s, got_w[i].l, exp_w[i].d, exp_w[i].s, exp_w[i].l);
               end
            end
         end
         checks++;
         if (done_cnt != base + 1 || done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL rand%0d_done: got %0d pulses at cyc %0d, want 1 at cyc %0d", f,
                     done_cnt - base, done_cyc, last_hs_cyc + 1);
         end
`ifdef OFMAP_PACKER_STATS_EN
         exp_cnt = exp_sat;
`else
         exp_cnt = 0;
`endif
         checks++;
         if (int'(sat_count) != exp_cnt) begin
            errors++; $display("FAIL rand%0d_sat: got %0d want %0d", f, sat_count, exp_cnt);
         end
      end
      rdy_rand = 1'b0;
   endtask

   task automatic test_async_reset();
      word_t e;
      in_vals = '{1, 2, 3, 4, 5, 6, 7, 8};
      do_start(8, 0, 1'b0);
      drive_elems(0, 5, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, o_valid, o_last, in_ready, o_data, o_strb} !== '0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b v=%b l=%b rdy=%b d=%h s=%h, want all 0",
                  busy, o_valid, o_last, in_ready, o_data, o_strb);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_vals = '{-1, 2, -3};
      run_frame(3, 0, 1'b0, 0);
      e = '{32'h00FD02FF, 4'h7, 1'b1};
      checks++;
      if (got_w.size() != 1 || got_w[0] !== e) begin
         errors++;
         $display("FAIL async_restart: got %0d words first %h/%h, want 1 word %h/%h", got_w.size(),
                  got_w.size() ? got_w[0].d : 0, got_w.size() ? got_w[0].s : 0, e.d, e.s);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_partial();
      test_requant();
      test_backpressure();
      test_clear();
      test_start_ignored();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
